// File: rtl/deserializer.sv
// Serial frame receiver: start(1), DATA_W payload bits, even parity, stop(0).
// Completed frames are checked one edge after the stop bit and delivered via a valid/ready holding register.
module deserializer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bad;
  logic              stop_bad;
  logic              done_q;
  logic              frame_good;
  logic              consume;

  assign busy       = (state != IDLE);
  assign frame_good = done_q && !par_bad && !stop_bad;
  assign consume    = out_valid && out_ready;

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == STOP);
      case (state)
        IDLE: begin
          if (data_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (LSB_FIRST) shift_reg <= {data_in, shift_reg[DATA_W-1:1]};
          else           shift_reg <= {shift_reg[DATA_W-2:0], data_in};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) state <= PARITY;
        end
        PARITY: begin
          par_bad <= (^shift_reg) ^ data_in;
          state   <= STOP;
        end
        STOP: begin
          stop_bad <= data_in;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delivery runs one edge behind the stop-bit sample, so shift_reg still holds
  // the finished word while a back-to-back start bit is being accepted.
  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= done_q && par_bad;
      frame_err  <= done_q && stop_bad;
      if (frame_good) begin
        if (!out_valid || out_ready) begin
          data_out  <= shift_reg;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: table of single frames plus hand-written
// sequences for back-to-back, overrun, mid-frame reset and MSB-first order.
module tb_deserializer;

  logic       t_clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       out_ready;
  logic [7:0] l_data, m_data;
  logic       l_valid, l_perr, l_ferr, l_ovr, l_busy;
  logic       m_valid, m_perr, m_ferr, m_ovr, m_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 t_clk = ~t_clk;

  deserializer #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (
    .t_clk(t_clk), .rst(rst), .data_in(data_in),
    .data_out(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .parity_err(l_perr), .frame_err(l_ferr), .overrun(l_ovr), .busy(l_busy)
  );

  deserializer #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (
    .t_clk(t_clk), .rst(rst), .data_in(data_in),
    .data_out(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .parity_err(m_perr), .frame_err(m_ferr), .overrun(m_ovr), .busy(m_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits are transmitted d[0] first; parity is even parity of d, optionally inverted.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    logic [10:0] bits;
    bits[0] = 1'b1;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = (^d) ^ flip;
    bits[10] = stop;
    for (int i = 0; i < 11; i++) begin
      @(negedge t_clk);
      data_in = bits[i];
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; data_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge t_clk);
    chk("rst_data", l_data, 8'h00);
    chk("rst_valid", l_valid, 1'b0);
    chk("rst_busy", l_busy, 1'b0);
    chk("rst_ovr", l_ovr, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge t_clk);

    // Single frames, consumer always ready
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop_bit);
      @(negedge t_clk);
      data_in = 1'b0;
      chk($sformatf("v%0d_early_valid", v), l_valid, 1'b0);
      @(negedge t_clk);
      chk($sformatf("v%0d_valid", v), l_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d_data", v), l_data, vecs[v].exp_data);
      chk($sformatf("v%0d_perr", v), l_perr, vecs[v].exp_perr);
      chk($sformatf("v%0d_ferr", v), l_ferr, vecs[v].exp_ferr);
      chk($sformatf("v%0d_ovr", v), l_ovr, 1'b0);
      chk($sformatf("v%0d_busy", v), l_busy, 1'b0);
      @(negedge t_clk);
      chk($sformatf("v%0d_valid_drop", v), l_valid, 1'b0);
      chk($sformatf("v%0d_perr_pulse", v), l_perr, 1'b0);
      chk($sformatf("v%0d_ferr_pulse", v), l_ferr, 1'b0);
      repeat (2) @(negedge t_clk);
    end

    // Errored frame followed immediately by a good one
    fork
      begin
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'h12, 1'b0, 1'b0);
      end
      begin
        repeat (13) @(negedge t_clk);
        chk("b2b_ferr", l_ferr, 1'b1);
        chk("b2b_err_noload", l_valid, 1'b0);
        chk("b2b_busy_next", l_busy, 1'b1);
      end
    join
    @(negedge t_clk);
    data_in = 1'b0;
    @(negedge t_clk);
    chk("b2b_data", l_data, 8'h12);
    chk("b2b_valid", l_valid, 1'b1);
    chk("b2b_ferr_clear", l_ferr, 1'b0);
    repeat (3) @(negedge t_clk);

    // Back-to-back good frames with a stalled consumer
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    @(negedge t_clk);
    data_in = 1'b0;
    @(negedge t_clk);
    chk("ovr_data", l_data, 8'h3C);
    chk("ovr_valid", l_valid, 1'b1);
    chk("ovr_set", l_ovr, 1'b1);
    out_ready = 1'b1;
    @(negedge t_clk);
    chk("ovr_valid_drop", l_valid, 1'b0);
    chk("ovr_sticky", l_ovr, 1'b1);
    repeat (2) @(negedge t_clk);

    // Reset after the 4th payload bit of 0xC3
    @(negedge t_clk); data_in = 1'b1;
    @(negedge t_clk); data_in = 1'b1;
    @(negedge t_clk); data_in = 1'b1;
    @(negedge t_clk); data_in = 1'b0;
    @(negedge t_clk); data_in = 1'b0;
    @(negedge t_clk);
    chk("mid_busy", l_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", l_data, 8'h00);
    chk("mid_rst_valid", l_valid, 1'b0);
    chk("mid_rst_ovr", l_ovr, 1'b0);
    chk("mid_rst_busy", l_busy, 1'b0);
    chk("mid_rst_flags", {l_perr, l_ferr}, 2'b00);
    @(negedge t_clk);
    data_in = 1'b0;
    @(negedge t_clk);
    rst = 1'b0;
    @(negedge t_clk);
    send_frame(8'h81, 1'b0, 1'b0);
    @(negedge t_clk);
    data_in = 1'b0;
    @(negedge t_clk);
    chk("post_rst_data", l_data, 8'h81);
    chk("post_rst_valid", l_valid, 1'b1);
    chk("post_rst_flags", {l_perr, l_ferr, l_ovr}, 3'b000);
    repeat (2) @(negedge t_clk);

    // MSB-first order: wire bits 0,0,0,0,1,1,1,1
    send_frame(8'hF0, 1'b0, 1'b0);
    @(negedge t_clk);
    data_in = 1'b0;
    @(negedge t_clk);
    chk("msb_order", m_data, 8'h0F);
    chk("lsb_order", l_data, 8'hF0);
    repeat (2) @(negedge t_clk);

    // Consume in the same cycle a new word completes
    out_ready = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0);
    @(negedge t_clk);
    data_in = 1'b0;
    @(negedge t_clk);
    chk("msb_81_data", m_data, 8'h81);
    chk("msb_81_valid", m_valid, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b0);
    @(negedge t_clk);
    data_in = 1'b0;
    out_ready = 1'b1;
    @(negedge t_clk);
    chk("swap_data", m_data, 8'h7E);
    chk("swap_valid", m_valid, 1'b1);
    chk("swap_ovr", m_ovr, 1'b0);
    @(negedge t_clk);
    chk("swap_drain", m_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
